// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: one instruction at a time through FETCH/DECODE/MREAD/EXEC/WRITE/COMMIT.
// Latency (zero-wait memories): A-instr 2 cycles, C-instr 4, +1 for an M read, +1 for an M write.
// Backpressure: each request holds its address/data until the matching valid/ack; the FSM just waits.
module hack_cpu_mc #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = WIDTH - 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              inst_req,
    output logic [ADDR_W-1:0] pc,
    input  logic              inst_valid,
    input  logic [WIDTH-1:0]  inst,
    output logic              mem_rd,
    input  logic              mem_rdvalid,
    input  logic [WIDTH-1:0]  inM,
    output logic              writeM,
    output logic [WIDTH-1:0]  outM,
    input  logic              mem_wack,
    output logic [ADDR_W-1:0] addressM,
    output logic              retire
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        WRITE,
        COMMIT
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [WIDTH-1:0]  aReg;
    logic [WIDTH-1:0]  dReg;
    logic [WIDTH-1:0]  ir;
    logic [WIDTH-1:0]  mReg;
    logic [WIDTH-1:0]  rReg;

    logic              isCInst;
    logic [WIDTH-1:0]  xZ;
    logic [WIDTH-1:0]  xN;
    logic [WIDTH-1:0]  yIn;
    logic [WIDTH-1:0]  yZ;
    logic [WIDTH-1:0]  yN;
    logic [WIDTH-1:0]  fOut;
    logic [WIDTH-1:0]  aluOut;
    logic              zr;
    logic              ng;
    logic              take;
    logic [ADDR_W-1:0] pcInc;

    assign isCInst  = ir[WIDTH-1];
    assign addressM = aReg[ADDR_W-1:0];
    assign outM     = rReg;
    assign pcInc    = pc + ADDR_W'(1);

    // Hack ALU: zx/nx/zy/ny/f/no live in ir[11:6], a-bit ir[12] selects M over A
    always_comb begin
        yIn    = ir[12] ? mReg : aReg;
        xZ     = ir[11] ? '0 : dReg;
        xN     = ir[10] ? ~xZ : xZ;
        yZ     = ir[9] ? '0 : yIn;
        yN     = ir[8] ? ~yZ : yZ;
        fOut   = ir[7] ? (xN + yN) : (xN & yN);
        aluOut = ir[6] ? ~fOut : fOut;
    end

    assign zr   = (rReg == '0);
    assign ng   = rReg[WIDTH-1];
    assign take = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);

    always_comb begin
        nextState = state;
        inst_req  = 1'b0;
        mem_rd    = 1'b0;
        writeM    = 1'b0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                inst_req = 1'b1;
                if (inst_valid) nextState = DECODE;
            end
            DECODE: begin
                if (!isCInst) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end else if (ir[12]) begin
                    nextState = MREAD;
                end else begin
                    nextState = EXEC;
                end
            end
            MREAD: begin
                mem_rd = 1'b1;
                if (mem_rdvalid) nextState = EXEC;
            end
            EXEC: begin
                nextState = ir[3] ? WRITE : COMMIT;
            end
            WRITE: begin
                writeM = 1'b1;
                if (mem_wack) nextState = COMMIT;
            end
            COMMIT: begin
                retire    = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
        // Reset masks every strobe so an in-flight handshake is dropped immediately
        if (reset) begin
            inst_req  = 1'b0;
            mem_rd    = 1'b0;
            writeM    = 1'b0;
            retire    = 1'b0;
            nextState = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            aReg  <= '0;
            dReg  <= '0;
            ir    <= '0;
            mReg  <= '0;
            rReg  <= '0;
        end else begin
            state <= nextState;
            case (state)
                FETCH: begin
                    if (inst_valid) ir <= inst;
                end
                DECODE: begin
                    if (!isCInst) begin
                        aReg <= {1'b0, ir[WIDTH-2:0]};
                        pc   <= pcInc;
                    end
                end
                MREAD: begin
                    if (mem_rdvalid) mReg <= inM;
                end
                EXEC: begin
                    rReg <= aluOut;
                end
                COMMIT: begin
                    // Jump target is the A value from before this instruction's A-dest write
                    if (ir[5]) aReg <= rReg;
                    if (ir[4]) dReg <= rReg;
                    pc <= take ? aReg[ADDR_W-1:0] : pcInc;
                end
                default: ;
            endcase
        end
    end

endmodule
